// File: rtl/dot_product_ctrl.sv
// dot_product_ctrl: sequencing controller for the dot-product datapath.
// The controller streams element pairs from RAM A and RAM B, starting at address 0.
// It multiply-accumulates each pair into an unsigned result.
// Host writes reach the RAMs only while the controller is not busy.
module dot_product_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   vec_len,
    output logic                  busy,
    output logic                  done,
    output logic [ACC_WIDTH-1:0]  result,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic [DATA_WIDTH-1:0] b_data,
    input  logic                  host_we,
    input  logic                  host_sel,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_data,
    output logic                  a_we,
    output logic                  b_we,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  host_wr_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Longest vector the RAMs can hold; longer requests are clamped to it.
    localparam logic [ADDR_WIDTH:0] MAX_LEN_C = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE_LEN_C = (ADDR_WIDTH+1)'(1);

    state_t                  state_r;
    logic [ADDR_WIDTH:0]     cnt_r;
    logic [ACC_WIDTH-1:0]    acc_r;
    logic                    vld_r;
    logic                    busy_r;
    logic                    done_r;
    logic [ACC_WIDTH-1:0]    result_r;
    logic                    rd_en_r;
    logic [ADDR_WIDTH-1:0]   rd_addr_r;
    logic                    host_wr_err_r;

    logic [ADDR_WIDTH:0]     len_s;
    logic [2*DATA_WIDTH-1:0] prod_s;
    logic [ACC_WIDTH-1:0]    prod_ext_s;

    assign len_s      = (vec_len > MAX_LEN_C) ? MAX_LEN_C : vec_len;
    assign prod_s     = {{DATA_WIDTH{1'b0}}, a_data} * {{DATA_WIDTH{1'b0}}, b_data};
    assign prod_ext_s = ACC_WIDTH'(prod_s);

    // The write path passes straight through to the RAMs and is gated by the registered busy flag.
    assign a_we    = host_we & ~host_sel & ~busy_r;
    assign b_we    = host_we &  host_sel & ~busy_r;
    assign wr_addr = host_addr;
    assign wr_data = host_data;

    assign busy        = busy_r;
    assign done        = done_r;
    assign result      = result_r;
    assign rd_en       = rd_en_r;
    assign rd_addr     = rd_addr_r;
    assign host_wr_err = host_wr_err_r;

    // Sequencing FSM: issues reads, runs the one-cycle valid pipe, and accumulates, with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            acc_r     <= '0;
            vld_r     <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            result_r  <= '0;
            rd_en_r   <= 1'b0;
            rd_addr_r <= '0;
        end else begin
            // Read data arrives one cycle after each issued read.
            vld_r <= rd_en_r;
            if (vld_r) begin
                acc_r <= acc_r + prod_ext_s;
            end
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        if (len_s == '0) begin
                            result_r <= '0;
                            done_r   <= 1'b1;
                            state_r  <= ST_DONE;
                        end else begin
                            cnt_r     <= len_s;
                            acc_r     <= '0;
                            rd_en_r   <= 1'b1;
                            rd_addr_r <= '0;
                            busy_r    <= 1'b1;
                            state_r   <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    cnt_r <= cnt_r - ONE_LEN_C;
                    if (cnt_r == ONE_LEN_C) begin
                        // Last read has been issued; the final pair lands during DRAIN.
                        rd_en_r <= 1'b0;
                        state_r <= ST_DRAIN;
                    end else begin
                        rd_addr_r <= rd_addr_r + ADDR_WIDTH'(1);
                    end
                end
                ST_DRAIN: begin
                    result_r <= acc_r + prod_ext_s;
                    busy_r   <= 1'b0;
                    done_r   <= 1'b1;
                    state_r  <= ST_DONE;
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    rd_en_r <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Flag a host write that was dropped because the controller was busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            host_wr_err_r <= 1'b0;
        end else begin
            host_wr_err_r <= host_we & busy_r;
        end
    end

endmodule

// File: tb/tb_dot_product_ctrl.sv
// Testbench for dot_product_ctrl. It models the two registered-read RAMs.
// It checks the controller against a behavioural dot-product reference.
module tb_dot_product_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  vec_len;
    logic        busy, done, rd_en;
    logic [19:0] result;
    logic [3:0]  rd_addr;
    logic [7:0]  a_data, b_data;
    logic        host_we, host_sel;
    logic [3:0]  host_addr;
    logic [7:0]  host_data;
    logic        a_we, b_we;
    logic [3:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        host_wr_err;

    int total = 0;
    int bad   = 0;

    // Contents the bench intends each RAM to hold.
    int ref_a [16];
    int ref_b [16];

    // The RAM images that the DUT actually drives.
    logic [7:0] ram_a [16];
    logic [7:0] ram_b [16];

    always #5 clk = ~clk;

    dot_product_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .vec_len(vec_len),
        .busy(busy), .done(done), .result(result),
        .rd_en(rd_en), .rd_addr(rd_addr), .a_data(a_data), .b_data(b_data),
        .host_we(host_we), .host_sel(host_sel), .host_addr(host_addr), .host_data(host_data),
        .a_we(a_we), .b_we(b_we), .wr_addr(wr_addr), .wr_data(wr_data),
        .host_wr_err(host_wr_err)
    );

    // Registered-read RAM pair with write ports.
    always @(posedge clk) begin
        if (a_we) ram_a[wr_addr] <= wr_data;
        if (b_we) ram_b[wr_addr] <= wr_data;
        if (rd_en) begin
            a_data <= ram_a[rd_addr];
            b_data <= ram_b[rd_addr];
        end
    end

    function automatic int ref_dot(input int n);
        int s = 0;
        int m = (n > 16) ? 16 : n;
        for (int i = 0; i < m; i++) s += ref_a[i] * ref_b[i];
        return s % (1 << 20);
    endfunction

    task automatic host_write(input bit sel, input int addr, input int data);
        @(negedge clk);
        host_we = 1'b1; host_sel = sel; host_addr = 4'(addr); host_data = 8'(data);
        #1;
        total++;
        if ((sel ? b_we : a_we) !== 1'b1 || (sel ? a_we : b_we) !== 1'b0) begin
            bad++; $display("FAIL idle_we got a_we=%b b_we=%b sel=%0d", a_we, b_we, sel);
        end
        total++;
        if (wr_addr !== 4'(addr) || wr_data !== 8'(data)) begin
            bad++; $display("FAIL wr_pass got %0h/%0h exp %0h/%0h", wr_addr, wr_data, addr, data);
        end
        if (sel) ref_b[addr] = data; else ref_a[addr] = data;
        @(posedge clk); #1;
        host_we = 1'b0;
    endtask

    // Start a run (optionally with a same-cycle write) and check timing and result cycle by cycle.
    task automatic do_run(input int n_in, input bit wr, input bit sel, input int waddr, input int wdata);
        int nc, exp_res, done_k;
        bit e_rd, e_busy, e_done;
        @(negedge clk);
        start = 1'b1; vec_len = 5'(n_in);
        if (wr) begin
            host_we = 1'b1; host_sel = sel; host_addr = 4'(waddr); host_data = 8'(wdata);
            #1;
            total++;
            if ((sel ? b_we : a_we) !== 1'b1) begin
                bad++; $display("FAIL start_wr_we got 0 exp 1");
            end
            if (sel) ref_b[waddr] = wdata; else ref_a[waddr] = wdata;
        end
        nc = (n_in > 16) ? 16 : n_in;
        exp_res = ref_dot(nc);
        done_k = (nc == 0) ? 1 : nc + 2;
        for (int k = 1; k <= nc + 4; k++) begin
            @(negedge clk);
            if (k == 1) begin start = 1'b0; host_we = 1'b0; end
            e_rd   = (k >= 1) && (k <= nc);
            e_busy = (nc > 0) && (k <= nc + 1);
            e_done = (k == done_k);
            total++;
            if (rd_en !== e_rd) begin
                bad++; $display("FAIL rd_en n=%0d k=%0d got=%b exp=%b", n_in, k, rd_en, e_rd);
            end
            if (e_rd) begin
                total++;
                if (rd_addr !== 4'(k - 1)) begin
                    bad++; $display("FAIL rd_addr n=%0d k=%0d got=%0d exp=%0d", n_in, k, rd_addr, k - 1);
                end
            end
            total++;
            if (busy !== e_busy) begin
                bad++; $display("FAIL busy n=%0d k=%0d got=%b exp=%b", n_in, k, busy, e_busy);
            end
            total++;
            if (done !== e_done) begin
                bad++; $display("FAIL done n=%0d k=%0d got=%b exp=%b", n_in, k, done, e_done);
            end
            if (k >= done_k) begin
                total++;
                if (result !== 20'(exp_res)) begin
                    bad++; $display("FAIL result n=%0d k=%0d got=%0d exp=%0d", n_in, k, result, exp_res);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || rd_en !== 1'b0 || rd_addr !== 4'd0 ||
            result !== 20'd0 || host_wr_err !== 1'b0) begin
            bad++; $display("FAIL reset got busy=%b done=%b rd_en=%b addr=%0d res=%0d err=%b exp all 0",
                            busy, done, rd_en, rd_addr, result, host_wr_err);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        for (int i = 0; i < 16; i++) begin
            host_write(1'b0, i, (i < 4) ? i + 1 : 0);
            host_write(1'b1, i, (i < 4) ? 2 : 0);
        end
        do_run(4, 1'b0, 1'b0, 0, 0);
        total++;
        if (result !== 20'd20) begin
            bad++; $display("FAIL basic_const got=%0d exp=20", result);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 16; i++) begin
            host_write(1'b0, i, 255);
            host_write(1'b1, i, 255);
        end
        do_run(16, 1'b0, 1'b0, 0, 0);
        total++;
        if (result !== 20'd1040400) begin
            bad++; $display("FAIL full16 got=%0d exp=1040400", result);
        end
        do_run(31, 1'b0, 1'b0, 0, 0);
        total++;
        if (result !== 20'd1040400) begin
            bad++; $display("FAIL clamp31 got=%0d exp=1040400", result);
        end
    endtask

    task automatic test_zero();
        do_run(0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_write_busy();
        @(negedge clk);
        start = 1'b1; vec_len = 5'd8;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            start = 1'b0;
            host_we = 1'b0;
            if (k == 2) begin
                host_we = 1'b1; host_sel = 1'b0; host_addr = 4'd0; host_data = 8'hAA;
                #1;
                total++;
                if (a_we !== 1'b0 || b_we !== 1'b0) begin
                    bad++; $display("FAIL busy_we got a_we=%b b_we=%b exp 0 0", a_we, b_we);
                end
            end
            if (k == 3 || k == 4) begin
                total++;
                if (host_wr_err !== (k == 3)) begin
                    bad++; $display("FAIL wr_err k=%0d got=%b exp=%b", k, host_wr_err, k == 3);
                end
            end
            if (k == 10) begin
                total++;
                if (done !== 1'b1 || result !== 20'(ref_dot(8))) begin
                    bad++; $display("FAIL busy_wr_result got done=%b res=%0d exp 1 %0d", done, result, ref_dot(8));
                end
            end
        end
    endtask

    task automatic test_same_cycle();
        host_write(1'b1, 0, 3);
        do_run(1, 1'b1, 1'b0, 0, 9);
        total++;
        if (result !== 20'd27) begin
            bad++; $display("FAIL same_cycle got=%0d exp=27", result);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start = 1'b1; vec_len = 5'd8;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 3) rst = 1'b1;
            if (k == 4) begin
                rst = 1'b0;
                total++;
                if (busy !== 1'b0 || rd_en !== 1'b0 || result !== 20'd0 || rd_addr !== 4'd0) begin
                    bad++; $display("FAIL mid_reset got busy=%b rd_en=%b res=%0d addr=%0d exp 0",
                                    busy, rd_en, result, rd_addr);
                end
            end
            if (k >= 4) begin
                total++;
                if (done !== 1'b0) begin
                    bad++; $display("FAIL mid_reset_done k=%0d got=1 exp=0", k);
                end
            end
        end
        do_run(8, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 16; i++) begin
                host_write(1'b0, i, int'($urandom_range(0, 255)));
                host_write(1'b1, i, int'($urandom_range(0, 255)));
            end
            do_run(int'($urandom_range(0, 31)), 1'b0, 1'b0, 0, 0);
            do_run(int'($urandom_range(1, 16)), 1'b0, 1'b0, 0, 0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; vec_len = 5'd0;
        host_we = 1'b0; host_sel = 1'b0; host_addr = 4'd0; host_data = 8'd0;
        test_reset();
        test_basic();
        test_full();
        test_zero();
        test_write_busy();
        test_same_cycle();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dot_product_ctrl.md
# dot_product_ctrl

Sequencing controller for the dot-product datapath. Owns the read ports of the two vector RAMs (A and B), streams element pairs from address 0 upward, and multiply-accumulates them into an unsigned result. Also arbitrates host write access to both RAMs: writes pass through only while the controller is idle.

## Interface

Parameters:
- ADDR_WIDTH, 4: RAM address width; maximum vector length is 2^ADDR_WIDTH.
- DATA_WIDTH, 8: element width, unsigned.
- ACC_WIDTH, 20: accumulator/result width.
  - Must be ≥ 2*DATA_WIDTH+ADDR_WIDTH; otherwise the sum wraps modulo 2^ACC_WIDTH.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  start request; sampled only in IDLE.
- vec_len  in  ADDR_WIDTH+1  element count N, sampled with start.
  - Values above 2^ADDR_WIDTH clamp to 2^ADDR_WIDTH.
- busy  out  1  high in READ and DRAIN.
- done  out  1  one-cycle pulse; result is valid.
- result  out  ACC_WIDTH  dot product; held until the next accepted start.
- rd_en  out  1  read enable, shared by RAM A and RAM B.
- rd_addr  out  ADDR_WIDTH  read address, shared.
- a_data  in  DATA_WIDTH  RAM A read data; registered, valid the cycle after rd_en.
- b_data  in  DATA_WIDTH  RAM B read data; same timing as a_data.
- host_we  in  1  host write request.
- host_sel  in  1  host target select: 0 = RAM A, 1 = RAM B.
- host_addr  in  ADDR_WIDTH  host write address.
- host_data  in  DATA_WIDTH  host write data.
- a_we, b_we  out  1 each  gated write enables:
  - a_we = host_we & ~host_sel & ~busy
  - b_we = host_we & host_sel & ~busy
- wr_addr, wr_data  out  ADDR_WIDTH, DATA_WIDTH  host_addr and host_data passed through combinationally.
- host_wr_err  out  1  registered one-cycle pulse, the cycle after host_we is seen while busy.

## Operation

- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE
  - start with N=0: go to DONE, with result=0 loaded.
  - start with N>0: load the length counter, clear acc, set rd_addr=0, go to READ.
- READ
  - rd_en=1 each cycle; rd_addr increments by 1.
  - After N issued reads, go to DRAIN.
- Valid pipe: a flag delayed one cycle from rd_en.
  - When set, acc <= acc + a_data*b_data.
  - The product is full 2*DATA_WIDTH bits, zero-extended to ACC_WIDTH.
- DRAIN: accumulates the final pair, loads result <= acc + last product, then goes to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. start is ignored in DONE.
- rd_addr wraps naturally.
  - With N = 2^ADDR_WIDTH the last read is at address 2^ADDR_WIDTH-1.
  - No read beyond N is ever issued.
- Host writes while busy are dropped (no RAM write) and flagged on host_wr_err.
- Host writes in IDLE or DONE always pass through.
- start and host_we in the same IDLE cycle:
  - The write commits at that edge.
  - The first read occurs on the following cycle, so it observes the new data.
- Reset at any time, including mid-operation, forces:
  - state=IDLE
  - busy=0, done=0, rd_en=0, rd_addr=0
  - acc=0, result=0, host_wr_err=0
  - The valid pipe is cleared.

## Timing

- start accepted at cycle T (N>0):
  - rd_en high T+1..T+N, with rd_addr = k-1 in cycle T+k.
  - Data pairs valid T+2..T+N+1.
  - busy high T+1..T+N+1.
  - done high in cycle T+N+2, with result valid in that same cycle.
- Latency from start to done is N+2 cycles.
- The next start is accepted at T+N+3 at the earliest.
- N=0: done at T+1, result=0, no rd_en, busy never asserts.
- Throughput: one element pair per cycle, no stalls.
- a_we, b_we, wr_addr and wr_data are combinational, with zero latency to the RAM.
- host_wr_err has 1-cycle latency.

## Test plan

- Reset, then preload A[i]=i+1 and B[i]=2 for i=0..3; start with vec_len=4.
  - Expect rd_addr 0,1,2,3 on consecutive cycles.
  - Expect done at T+6 with result=20.
  - Expect busy high for exactly 5 cycles.
- Full length, all ones: A=B=255 everywhere; vec_len=16 (and again with vec_len=31, which clamps).
  - Expect result=1040400 with no overflow.
  - Expect the last rd_addr=15 and exactly 16 reads.
- vec_len=0: expect done at T+1, result=0, rd_en never high.
  - result from a prior run is overwritten by 0.
- host_we=1, host_sel=0 during READ:
  - Expect a_we=0 and host_wr_err pulsed one cycle later.
  - RAM contents unchanged; result unaffected.
- Same-cycle start and write of A[0]=9 (B[0]=3, vec_len=1):
  - Expect result=27 at T+3.
- rst asserted at T+3 of a vec_len=8 run:
  - Next cycle: busy=0, rd_en=0, result=0, done never pulses.
  - A fresh start then completes normally.
